// File: rtl/axi_inf_write_burst_scheduler_if.sv
// Handshake bundle between the frame controller, the burst scheduler and the write state core.
// The master modport is the scheduler's view.
interface axi_inf_write_burst_scheduler_if #(
  parameter int LSIZE = 10,
  parameter int ASIZE = 32,
  parameter int TSIZE = 24
);
  logic             start;
  logic             abort;
  logic [ASIZE-1:0] base_addr;
  logic [TSIZE-1:0] total_beats;
  logic             busy;
  logic             frame_done;
  logic             frame_aborted;
  logic             core_req;
  logic [LSIZE-1:0] core_len;
  logic [ASIZE-1:0] core_addr;
  logic             core_resp;
  logic             core_done;

  modport master (
    input  start, abort, base_addr, total_beats, core_resp, core_done,
    output busy, frame_done, frame_aborted, core_req, core_len, core_addr
  );

  modport slave (
    output start, abort, base_addr, total_beats, core_resp, core_done,
    input  busy, frame_done, frame_aborted, core_req, core_len, core_addr
  );
endinterface

// File: rtl/axi_inf_write_burst_scheduler.sv
// Splits one frame write into AXI INCR bursts (<= BURST_MAX beats, never crossing 4 KB)
// and hands them to the write state core one at a time.
//   state  | meaning
//   IDLE   | waiting for start
//   CALC   | compute next burst length
//   REQ    | core_req high until core_resp
//   WAIT   | waiting for core_done, then advance addr/rem
//   FINISH | one-cycle frame_done
module axi_inf_write_burst_scheduler #(
  parameter int LSIZE          = 10,
  parameter int ASIZE          = 32,
  parameter int TSIZE          = 24,
  parameter int BURST_MAX      = 64,
  parameter int BYTES_PER_BEAT = 32
) (
  input logic axi_aclk,
  input logic axi_reset,
  axi_inf_write_burst_scheduler_if.master bus
);

  localparam int BSHIFT = $clog2(BYTES_PER_BEAT);
  localparam int CW     = (TSIZE > 13) ? TSIZE : 13;

  typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT, FINISH} state_t;

  state_t           state, state_next;
  logic [ASIZE-1:0] addr;
  logic [TSIZE-1:0] rem;
  logic [LSIZE-1:0] len;
  logic             abort_flag;
  logic             aborted;

  logic [12:0]      bnd_beats;
  logic [CW-1:0]    cap;
  logic [CW-1:0]    len_calc;
  logic [TSIZE-1:0] rem_after;
  logic             abort_eff;
  logic             busy_int;

  always_comb begin
    bnd_beats = (13'd4096 - {1'b0, addr[11:0]}) >> BSHIFT;
    cap       = (CW'(bnd_beats) < CW'(BURST_MAX)) ? CW'(bnd_beats) : CW'(BURST_MAX);
    len_calc  = (CW'(rem) < cap) ? CW'(rem) : cap;
    rem_after = rem - TSIZE'(len);
    // an abort arriving on the same cycle as core_done still stops further bursts
    abort_eff = abort_flag | bus.abort;
    busy_int  = (state == CALC) || (state == REQ) || (state == WAIT);
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = (bus.total_beats == '0) ? FINISH : CALC;
      CALC:    state_next = REQ;
      REQ:     if (bus.core_resp) state_next = WAIT;
      WAIT:    if (bus.core_done) state_next = ((rem_after == '0) || abort_eff) ? FINISH : CALC;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      addr       <= '0;
      rem        <= '0;
      len        <= '0;
      abort_flag <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (busy_int && bus.abort) abort_flag <= 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          addr    <= bus.base_addr & ~ASIZE'(BYTES_PER_BEAT - 1);
          rem     <= bus.total_beats;
          aborted <= 1'b0;
        end
        CALC: len <= LSIZE'(len_calc);
        WAIT: if (bus.core_done) begin
          addr    <= addr + (ASIZE'(len) << BSHIFT);
          rem     <= rem_after;
          aborted <= abort_eff && (rem_after != '0);
        end
        FINISH: abort_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy          = busy_int;
  assign bus.core_req      = (state == REQ);
  assign bus.frame_done    = (state == FINISH);
  assign bus.frame_aborted = (state == FINISH) && aborted;
  assign bus.core_len      = len;
  assign bus.core_addr     = addr;

endmodule

// File: tb/tb_axi_inf_write_burst_scheduler.sv
// Bench for the burst scheduler: expected bursts are queued when a frame is started and
// compared as the modelled core accepts each request.
module tb_axi_inf_write_burst_scheduler;

  typedef struct {
    logic [31:0] addr;
    logic [9:0]  len;
  } burst_t;

  logic axi_aclk = 1'b0;
  logic axi_reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  burst_t exp_q[$];

  always #5 axi_aclk = ~axi_aclk;

  axi_inf_write_burst_scheduler_if #(.LSIZE(10), .ASIZE(32), .TSIZE(24)) bus ();

  axi_inf_write_burst_scheduler #(
    .LSIZE(10), .ASIZE(32), .TSIZE(24), .BURST_MAX(64), .BYTES_PER_BEAT(32)
  ) dut (
    .axi_aclk (axi_aclk),
    .axi_reset(axi_reset),
    .bus      (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input logic [31:0] base, input logic [23:0] total);
    @(negedge axi_aclk);
    bus.base_addr   = base;
    bus.total_beats = total;
    bus.start       = 1'b1;
    @(negedge axi_aclk);
    bus.start = 1'b0;
  endtask

  // Core model: waits (bounded) for core_req, answers after resp_delay, then optionally completes.
  task automatic serve(input int resp_delay, input bit give_done,
                       output logic [31:0] a, output logic [9:0] l, output bit ok);
    ok = 1'b0; a = '0; l = '0;
    for (int i = 0; i < 50 && !bus.core_req; i++) @(negedge axi_aclk);
    if (!bus.core_req) return;
    a = bus.core_addr;
    l = bus.core_len;
    repeat (resp_delay) @(negedge axi_aclk);
    bus.core_resp = 1'b1;
    @(negedge axi_aclk);
    bus.core_resp = 1'b0;
    repeat (2) @(negedge axi_aclk);
    if (give_done) begin
      bus.core_done = 1'b1;
      @(negedge axi_aclk);
      bus.core_done = 1'b0;
    end
    ok = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge axi_aclk);
    checks++;
    if ({bus.busy, bus.frame_done, bus.frame_aborted, bus.core_req} !== 4'b0 ||
        bus.core_len !== 10'd0 || bus.core_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b req=%b len=%0d addr=%0h required all 0",
               bus.busy, bus.frame_done, bus.core_req, bus.core_len, bus.core_addr);
    end
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_multi(input string name, input logic [31:0] base, input logic [23:0] total,
                            input burst_t b0, input burst_t b1);
    burst_t e;
    logic [31:0] a;
    logic [9:0] l;
    bit ok;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    start_frame(base, total);
    checks++;
    if (bus.busy !== 1'b1 || bus.core_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_latency got busy=%b req=%b required busy=1 req=0", name, bus.busy, bus.core_req);
    end
    @(negedge axi_aclk);
    checks++;
    if (bus.core_req !== 1'b1) begin
      failures++;
      $display("FAIL %s_req_latency got req=%b required 1", name, bus.core_req);
    end
    while (exp_q.size() > 0) begin
      serve(0, 1'b1, a, l, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || a !== e.addr || l !== e.len) begin
        failures++;
        $display("FAIL %s_burst got ok=%0d addr=%0h len=%0d required addr=%0h len=%0d",
                 name, ok, a, l, e.addr, e.len);
      end
      checks++;
      if (ok && ({20'd0, a[11:0]} + 32'(l) * 32) > 32'd4096) begin
        failures++;
        $display("FAIL %s_4k_cross got addr=%0h len=%0d required no 4KB crossing", name, a, l);
      end
      if (!ok) begin
        exp_q.delete();
        break;
      end
      checks++;
      if (bus.frame_done !== (exp_q.size() == 0)) begin
        failures++;
        $display("FAIL %s_frame_done got %b required %b", name, bus.frame_done, exp_q.size() == 0);
      end
    end
    checks++;
    if (bus.frame_aborted !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end_state got aborted=%b busy=%b required 0 0", name, bus.frame_aborted, bus.busy);
    end
    @(negedge axi_aclk);
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got %b required 0", name, bus.frame_done);
    end
  endtask

  task automatic test_empty();
    int bad = 0;
    start_frame(32'h123, 24'd0);
    checks++;
    if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.frame_aborted !== 1'b0) begin
      failures++;
      $display("FAIL empty_done got done=%b busy=%b aborted=%b required 1 0 0",
               bus.frame_done, bus.busy, bus.frame_aborted);
    end
    repeat (6) begin
      @(negedge axi_aclk);
      if (bus.core_req !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL empty_quiet got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_abort();
    burst_t e;
    logic [31:0] a;
    logic [9:0] l;
    bit ok;
    int extra = 0;
    exp_q.push_back('{32'h0, 10'd64});
    start_frame(32'h0, 24'd192);
    bus.abort = 1'b1;
    @(negedge axi_aclk);
    bus.abort = 1'b0;
    serve(0, 1'b1, a, l, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e.addr || l !== e.len) begin
      failures++;
      $display("FAIL abort_burst got ok=%0d addr=%0h len=%0d required addr=%0h len=%0d",
               ok, a, l, e.addr, e.len);
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.frame_aborted !== 1'b1) begin
      failures++;
      $display("FAIL abort_done got done=%b aborted=%b required 1 1", bus.frame_done, bus.frame_aborted);
    end
    repeat (10) begin
      @(negedge axi_aclk);
      if (bus.core_req !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL abort_no_more_bursts got %0d active cycles required 0", extra);
    end
  endtask

  task automatic test_resp_delay();
    burst_t e;
    int unstable = 0;
    int active = 0;
    int waited = 0;
    exp_q.push_back('{32'h100, 10'd10});
    start_frame(32'h100, 24'd10);
    while (!bus.core_req && waited < 50) begin
      @(negedge axi_aclk);
      waited++;
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.core_req !== 1'b1 || bus.core_addr !== e.addr || bus.core_len !== e.len) begin
      failures++;
      $display("FAIL delay_req got req=%b addr=%0h len=%0d required 1 addr=%0h len=%0d",
               bus.core_req, bus.core_addr, bus.core_len, e.addr, e.len);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.base_addr = 32'h2000;
        bus.total_beats = 24'd3;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge axi_aclk);
      if (bus.core_req !== 1'b1 || bus.core_addr !== e.addr || bus.core_len !== e.len) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL delay_hold got %0d unstable cycles required 0", unstable);
    end
    bus.core_resp = 1'b1;
    @(negedge axi_aclk);
    bus.core_resp = 1'b0;
    checks++;
    if (bus.core_req !== 1'b0) begin
      failures++;
      $display("FAIL delay_req_drop got req=%b required 0", bus.core_req);
    end
    @(negedge axi_aclk);
    bus.core_done = 1'b1;
    @(negedge axi_aclk);
    bus.core_done = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b1 || bus.frame_aborted !== 1'b0) begin
      failures++;
      $display("FAIL delay_done got done=%b aborted=%b required 1 0", bus.frame_done, bus.frame_aborted);
    end
    repeat (10) begin
      @(negedge axi_aclk);
      if (bus.core_req !== 1'b0 || bus.busy !== 1'b0) active++;
    end
    checks++;
    if (active != 0) begin
      failures++;
      $display("FAIL delay_start_ignored got %0d active cycles required 0", active);
    end
  endtask

  task automatic test_reset_mid();
    burst_t e;
    logic [31:0] a;
    logic [9:0] l;
    bit ok;
    start_frame(32'h0, 24'd100);
    serve(0, 1'b0, a, l, ok);
    #2 axi_reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.frame_done, bus.frame_aborted, bus.core_req} !== 4'b0 ||
        bus.core_len !== 10'd0 || bus.core_addr !== 32'd0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b done=%b req=%b len=%0d addr=%0h required all 0",
               bus.busy, bus.frame_done, bus.core_req, bus.core_len, bus.core_addr);
    end
    @(negedge axi_aclk);
    axi_reset = 1'b0;
    exp_q.push_back('{32'h40, 10'd4});
    start_frame(32'h40, 24'd4);
    serve(0, 1'b1, a, l, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || a !== e.addr || l !== e.len) begin
      failures++;
      $display("FAIL midreset_burst got ok=%0d addr=%0h len=%0d required addr=%0h len=%0d",
               ok, a, l, e.addr, e.len);
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.frame_aborted !== 1'b0) begin
      failures++;
      $display("FAIL midreset_done got done=%b aborted=%b required 1 0", bus.frame_done, bus.frame_aborted);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.base_addr = '0;
    bus.total_beats = '0;
    bus.core_resp = 1'b0;
    bus.core_done = 1'b0;
    test_reset();
    test_multi("split", 32'h0, 24'd100, '{32'h0, 10'd64}, '{32'h800, 10'd36});
    test_multi("cross4k", 32'hF00, 24'd20, '{32'hF00, 10'd8}, '{32'h1000, 10'd12});
    test_empty();
    test_abort();
    test_multi("post_abort", 32'h1F, 24'd70, '{32'h0, 10'd64}, '{32'h800, 10'd6});
    test_resp_delay();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
